// File: rtl/al_phy_clk_pkg.sv
// Shared types and divisor helpers for the multi-channel clock divider.
package al_phy_clk_pkg;

    typedef enum logic [1:0] {HOLD, WAIT_RLS, RUN} state_t;

    localparam int unsigned DIV_MIN  = 2;
    localparam int unsigned DIV_SAFE = 2;

    // Divisors below the minimum would stall or degenerate the counter; fall back to /2.
    function automatic int unsigned div_sanitise(input int unsigned div);
        return (div < DIV_MIN) ? DIV_SAFE : div;
    endfunction

endpackage

// File: rtl/al_phy_clkdiv_chan.sv
// One divider channel: period counter, latched divisor/high-time and sticky divisor error.
module al_phy_clkdiv_chan
    import al_phy_clk_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clki,
    input  logic          rst,
    input  logic          start,
    input  logic          run,
    input  logic          stop,
    input  logic [DW-1:0] div_in,
    output logic          clkdivx,
    output logic          ce,
    output logic          div_err
);

    localparam logic [DW-1:0] ONE      = DW'(1);
    localparam logic [DW-1:0] DIV_RST  = DW'(DIV_SAFE);
    localparam logic [DW-1:0] H_RST    = DW'((DIV_SAFE + 1) / 2);

    logic [DW-1:0] cnt_reg, div_q_reg, h_q_reg;
    logic [DW-1:0] cnt_next, div_san, h_san, h_use;
    logic [DW:0]   div_p1;
    logic          illegal, wrap;
    logic          clkdivx_reg, ce_reg, div_err_reg;

    assign illegal = (32'(div_in) < DIV_MIN);
    assign div_san = DW'(div_sanitise(32'(div_in)));
    // One extra bit so ceil(div/2) stays correct for the largest divisor.
    assign div_p1  = {1'b0, div_san} + (DW+1)'(1);
    assign h_san   = DW'(div_p1 >> 1);

    assign wrap     = (cnt_reg == div_q_reg - ONE);
    assign cnt_next = wrap ? '0 : cnt_reg + ONE;
    assign h_use    = wrap ? h_san : h_q_reg;

    always_ff @(posedge clki) begin
        if (rst) begin
            cnt_reg     <= '0;
            div_q_reg   <= DIV_RST;
            h_q_reg     <= H_RST;
            clkdivx_reg <= 1'b0;
            ce_reg      <= 1'b0;
            div_err_reg <= 1'b0;
        end else if (start) begin
            // Preload to the last count so the very next edge wraps and rises.
            div_q_reg   <= div_san;
            h_q_reg     <= h_san;
            cnt_reg     <= div_san - ONE;
            clkdivx_reg <= 1'b0;
            ce_reg      <= 1'b0;
            if (illegal) begin
                div_err_reg <= 1'b1;
            end
        end else if (run) begin
            cnt_reg     <= cnt_next;
            clkdivx_reg <= (cnt_next < h_use);
            ce_reg      <= wrap;
            if (wrap) begin
                div_q_reg <= div_san;
                h_q_reg   <= h_san;
                if (illegal) begin
                    div_err_reg <= 1'b1;
                end
            end
        end else if (stop) begin
            clkdivx_reg <= 1'b0;
            ce_reg      <= 1'b0;
        end
    end

    assign clkdivx = clkdivx_reg;
    assign ce      = ce_reg;
    assign div_err = div_err_reg;

endmodule

// File: rtl/al_phy_clkdiv_n.sv
// Multi-channel phase-aligned clock divider: hold/release sequencing plus NCH divider channels.
module al_phy_clkdiv_n
    import al_phy_clk_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic              clki,
    input  logic              rst,
    input  logic              rls,
    input  logic [NCH*DW-1:0] div_in,
    output logic [NCH-1:0]    clkdivx,
    output logic [NCH-1:0]    ce,
    output logic              locked,
    output logic [NCH-1:0]    div_err
);

    state_t     state_reg, state_next;
    logic [2:0] hold_cnt_reg;
    logic       hold_done;
    logic       locked_reg;
    logic       start, run, stop;

    assign hold_done = (hold_cnt_reg == 3'(HOLD_CYC - 1));

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        run        = 1'b0;
        stop       = 1'b0;
        case (state_reg)
            HOLD: begin
                if (hold_done) begin
                    state_next = WAIT_RLS;
                end
            end
            WAIT_RLS: begin
                if (rls) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A stop on a wrap edge wins: no divisor sample is taken.
                if (rls) begin
                    run = 1'b1;
                end else begin
                    stop       = 1'b1;
                    state_next = WAIT_RLS;
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == HOLD && !hold_done) begin
                hold_cnt_reg <= hold_cnt_reg + 3'd1;
            end
            locked_reg <= run;
        end
    end

    assign locked = locked_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            al_phy_clkdiv_chan #(
                .DW(DW)
            ) u_chan (
                .clki    (clki),
                .rst     (rst),
                .start   (start),
                .run     (run),
                .stop    (stop),
                .div_in  (div_in[gi*DW +: DW]),
                .clkdivx (clkdivx[gi]),
                .ce      (ce[gi]),
                .div_err (div_err[gi])
            );
        end
    endgenerate

endmodule
